// File: rtl/rv32_pkg.sv
// Shared RV32I decode definitions: opcodes, CCR select bit positions, skid states, decoded entry.
// Combinational helpers only; no timing or backpressure of its own.
package rv32_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam int CCR_EQ  = 5;
    localparam int CCR_NE  = 4;
    localparam int CCR_LT  = 3;
    localparam int CCR_GE  = 2;
    localparam int CCR_LTU = 1;
    localparam int CCR_GEU = 0;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } skid_state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        jump;
        logic [5:0]  br_sel;
        logic        illegal;
    } dec_entry_t;

    function automatic logic [5:0] br_sel_onehot(input logic [2:0] funct3);
        logic [5:0] sel;
        sel = '0;
        case (funct3)
            3'b000:  sel[CCR_EQ]  = 1'b1;
            3'b001:  sel[CCR_NE]  = 1'b1;
            3'b100:  sel[CCR_LT]  = 1'b1;
            3'b101:  sel[CCR_GE]  = 1'b1;
            3'b110:  sel[CCR_LTU] = 1'b1;
            3'b111:  sel[CCR_GEU] = 1'b1;
            default: sel = '0;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/rv32_imm_gen.sv
// Immediate builder: sign/zero extended I, U, J and B immediates from the instruction word.
// Purely combinational, no backpressure.
module rv32_imm_gen (
    input  logic [31:7] instr,
    output logic [31:0] imm_i,
    output logic [31:0] imm_u,
    output logic [31:0] imm_j,
    output logic [31:0] imm_b
);

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{12{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
    assign imm_b = {{20{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};

endmodule

// File: rtl/rv32_decode_stage.sv
// RV32I decode to ALU operands; B-type branches are legal only with DECODE_BRANCH_EN defined.
// Latency: accept at edge N, entry valid after edge N; 2-entry skid buffer holds order.
// Backpressure: in_ready comes from the skid state register and drops only when both entries are full.
module rv32_decode_stage
    import rv32_pkg::*;
#(
    parameter int XLEN        = 32,
    parameter int LINK_OFFSET = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [6:0]      out_opcode,
    output logic [2:0]      out_funct3,
    output logic [6:0]      out_funct7,
    output logic [XLEN-1:0] out_a,
    output logic [XLEN-1:0] out_b,
    output logic [4:0]      out_rd,
    output logic            out_we,
    output logic [XLEN-1:0] out_pc,
    output logic [XLEN-1:0] out_tgt,
    output logic            out_jump,
    output logic [5:0]      out_br_sel,
    output logic            out_illegal
);

    logic [31:0] imm_i, imm_u, imm_j, imm_b;
    logic [31:0] rs1_val, rs2_val, tgt_base, tgt_off, tgt_sum;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    logic        legal, writes, accept;
    logic        ld_main_new, ld_main_skid, ld_skid_new;
    dec_entry_t  dec, main_q, skid_q;
    skid_state_t state, state_nxt;

    rv32_imm_gen u_imm_gen (
        .instr (in_instr[31:7]),
        .imm_i (imm_i),
        .imm_u (imm_u),
        .imm_j (imm_j),
        .imm_b (imm_b)
    );

    assign opc      = in_instr[6:0];
    assign f3       = in_instr[14:12];
    assign f7       = in_instr[31:25];
    assign rs1_addr = in_instr[19:15];
    assign rs2_addr = in_instr[24:20];
    assign rs1_val  = (rs1_addr == 5'd0) ? '0 : rs1_data;
    assign rs2_val  = (rs2_addr == 5'd0) ? '0 : rs2_data;

    // One adder serves JAL, JALR and branch targets.
    always_comb begin
        tgt_base = in_pc;
        tgt_off  = imm_b;
        case (opc)
            OP_JAL:  tgt_off = imm_j;
            OP_JALR: begin
                tgt_base = rs1_val;
                tgt_off  = imm_i;
            end
            default: ;
        endcase
    end
    assign tgt_sum = tgt_base + tgt_off;

    always_comb begin
        dec        = '0;
        dec.opcode = opc;
        dec.funct3 = f3;
        dec.funct7 = f7;
        dec.pc     = in_pc;
        legal      = 1'b0;
        writes     = 1'b0;
        case (opc)
            OP_R: begin
                legal  = (f7 == 7'b0000000) ||
                         (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101));
                writes = 1'b1;
                dec.a  = rs1_val;
                dec.b  = rs2_val;
            end
            OP_IMM: begin
                writes = 1'b1;
                dec.a  = rs1_val;
                // Shifts hand the ALU a clean shamt; funct7 travels separately.
                if (f3 == 3'b001) begin
                    legal = (f7 == 7'b0000000);
                    dec.b = {27'b0, in_instr[24:20]};
                end else if (f3 == 3'b101) begin
                    legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
                    dec.b = {27'b0, in_instr[24:20]};
                end else begin
                    legal = 1'b1;
                    dec.b = imm_i;
                end
            end
            OP_LUI: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.a  = imm_u;
            end
            OP_AUIPC: begin
                legal  = 1'b1;
                writes = 1'b1;
                dec.a  = in_pc;
                dec.b  = imm_u;
            end
            OP_JAL: begin
                legal    = 1'b1;
                writes   = 1'b1;
                dec.a    = in_pc;
                dec.b    = 32'(LINK_OFFSET);
                dec.tgt  = tgt_sum;
                dec.jump = 1'b1;
            end
            OP_JALR: begin
                legal    = (f3 == 3'b000);
                writes   = 1'b1;
                dec.a    = in_pc;
                dec.b    = 32'(LINK_OFFSET);
                dec.tgt  = {tgt_sum[31:1], 1'b0};
                dec.jump = 1'b1;
            end
`ifdef DECODE_BRANCH_EN
            OP_BRANCH: begin
                legal      = (f3 != 3'b010) && (f3 != 3'b011);
                dec.a      = rs1_val;
                dec.b      = rs2_val;
                dec.tgt    = tgt_sum;
                dec.br_sel = br_sel_onehot(f3);
            end
`endif
            default: legal = 1'b0;
        endcase
        if (!legal) begin
            dec.a      = '0;
            dec.b      = '0;
            dec.tgt    = '0;
            dec.jump   = 1'b0;
            dec.br_sel = '0;
        end
        dec.illegal = !legal;
        dec.we      = legal && writes && (in_instr[11:7] != 5'd0);
        dec.rd      = dec.we ? in_instr[11:7] : 5'd0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_EMPTY;
        else        state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (flush) begin
            state_nxt = ST_EMPTY;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state_nxt = ST_ONE;
                ST_ONE: begin
                    if (accept && !out_ready)      state_nxt = ST_TWO;
                    else if (!accept && out_ready) state_nxt = ST_EMPTY;
                end
                ST_TWO:   if (out_ready) state_nxt = ST_ONE;
                default:  state_nxt = ST_EMPTY;
            endcase
        end
    end

    always_comb begin
        in_ready     = (state != ST_TWO);
        out_valid    = (state != ST_EMPTY);
        accept       = in_valid && in_ready;
        ld_main_new  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid_new  = 1'b0;
        if (!flush) begin
            case (state)
                ST_EMPTY: ld_main_new = accept;
                ST_ONE: begin
                    ld_main_new = accept && out_ready;
                    ld_skid_new = accept && !out_ready;
                end
                ST_TWO:   ld_main_skid = out_ready;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= '0;
            skid_q <= '0;
        end else begin
            if (ld_main_new)       main_q <= dec;
            else if (ld_main_skid) main_q <= skid_q;
            if (ld_skid_new)       skid_q <= dec;
        end
    end

    assign out_opcode  = main_q.opcode;
    assign out_funct3  = main_q.funct3;
    assign out_funct7  = main_q.funct7;
    assign out_a       = main_q.a;
    assign out_b       = main_q.b;
    assign out_rd      = main_q.rd;
    assign out_we      = main_q.we;
    assign out_pc      = main_q.pc;
    assign out_tgt     = main_q.tgt;
    assign out_jump    = main_q.jump;
    assign out_br_sel  = main_q.br_sel;
    assign out_illegal = main_q.illegal;

endmodule

// File: tb/tb_rv32_decode_stage.sv
// Bench for rv32_decode_stage: directed encodings, skid ordering, flush, async reset, random scoreboard.
module tb_rv32_decode_stage;

    logic        clk = 1'b0;
    logic        rst_n, flush, in_valid, in_ready, out_valid, out_ready;
    logic [31:0] in_instr, in_pc, rs1_data, rs2_data;
    logic [4:0]  rs1_addr, rs2_addr, out_rd;
    logic [6:0]  out_opcode, out_funct7;
    logic [2:0]  out_funct3;
    logic [31:0] out_a, out_b, out_pc, out_tgt;
    logic        out_we, out_jump, out_illegal;
    logic [5:0]  out_br_sel;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic        we;
        logic [31:0] pc;
        logic [31:0] tgt;
        logic        jump;
        logic [5:0]  br_sel;
        logic        illegal;
    } exp_t;

    rv32_decode_stage dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_funct3(out_funct3), .out_funct7(out_funct7),
        .out_a(out_a), .out_b(out_b), .out_rd(out_rd), .out_we(out_we), .out_pc(out_pc),
        .out_tgt(out_tgt), .out_jump(out_jump), .out_br_sel(out_br_sel), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic exp_t dut_out();
        return {out_opcode, out_funct3, out_funct7, out_a, out_b, out_rd, out_we,
                out_pc, out_tgt, out_jump, out_br_sel, out_illegal};
    endfunction

    // Reference decode written straight from the RV32I encoding rules.
    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc,
                                   input logic [31:0] d1, input logic [31:0] d2);
        exp_t e;
        logic [31:0] v1, v2, ii, iu, ij;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic        ok, wr;
        f3 = ins[14:12];
        f7 = ins[31:25];
        e = '0;
        e.opcode = ins[6:0];
        e.funct3 = f3;
        e.funct7 = f7;
        e.pc     = pc;
        v1 = (ins[19:15] == 5'd0) ? 32'd0 : d1;
        v2 = (ins[24:20] == 5'd0) ? 32'd0 : d2;
        ii = {{20{ins[31]}}, ins[31:20]};
        iu = {ins[31:12], 12'h000};
        ij = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        ok = 1'b0;
        wr = 1'b0;
        case (ins[6:0])
            7'b0110011: begin
                ok = (f7 == 7'd0) || (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5));
                wr = 1'b1; e.a = v1; e.b = v2;
            end
            7'b0010011: begin
                wr = 1'b1; e.a = v1;
                if (f3 == 3'd1) begin
                    ok = (f7 == 7'd0); e.b = {27'd0, ins[24:20]};
                end else if (f3 == 3'd5) begin
                    ok = (f7 == 7'd0) || (f7 == 7'b0100000); e.b = {27'd0, ins[24:20]};
                end else begin
                    ok = 1'b1; e.b = ii;
                end
            end
            7'b0110111: begin ok = 1'b1; wr = 1'b1; e.a = iu; e.b = 32'd0; end
            7'b0010111: begin ok = 1'b1; wr = 1'b1; e.a = pc; e.b = iu; end
            7'b1101111: begin
                ok = 1'b1; wr = 1'b1; e.a = pc; e.b = 32'd4; e.tgt = pc + ij; e.jump = 1'b1;
            end
            7'b1100111: begin
                ok = (f3 == 3'd0); wr = 1'b1; e.a = pc; e.b = 32'd4;
                e.tgt = (v1 + ii) & 32'hFFFF_FFFE; e.jump = 1'b1;
            end
`ifdef DECODE_BRANCH_EN
            7'b1100011: begin
                ok = (f3 != 3'd2) && (f3 != 3'd3);
                e.a = v1; e.b = v2;
                e.tgt = pc + {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
                case (f3)
                    3'd0: e.br_sel = 6'b100000;
                    3'd1: e.br_sel = 6'b010000;
                    3'd4: e.br_sel = 6'b001000;
                    3'd5: e.br_sel = 6'b000100;
                    3'd6: e.br_sel = 6'b000010;
                    3'd7: e.br_sel = 6'b000001;
                    default: e.br_sel = 6'b000000;
                endcase
            end
`endif
            default: ok = 1'b0;
        endcase
        if (!ok) begin
            e.a = 32'd0; e.b = 32'd0; e.tgt = 32'd0; e.jump = 1'b0; e.br_sel = 6'd0;
            e.illegal = 1'b1;
        end else if (wr && ins[11:7] != 5'd0) begin
            e.we = 1'b1; e.rd = ins[11:7];
        end
        return e;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        w = $urandom;
        case ($urandom_range(0, 7))
            0: w[6:0] = 7'b0110011;
            1: w[6:0] = 7'b0010011;
            2: w[6:0] = 7'b0110111;
            3: w[6:0] = 7'b0010111;
            4: w[6:0] = 7'b1101111;
            5: begin w[6:0] = 7'b1100111; if ($urandom_range(0, 3) != 0) w[14:12] = 3'd0; end
            6: w[6:0] = 7'b1100011;
            default: ;
        endcase
        if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'b0100000 : 7'b0000000;
        if ($urandom_range(0, 3) == 0) w[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) w[24:20] = 5'd0;
        if ($urandom_range(0, 5) == 0) w[11:7]  = 5'd0;
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] d1, input logic [31:0] d2);
        in_valid = v; in_instr = ins; in_pc = pc; rs1_data = d1; rs2_data = d2;
    endtask

    // Present one instruction for a single accepting cycle, then idle the input.
    task automatic run_one(input logic [31:0] ins, input logic [31:0] pc,
                           input logic [31:0] d1, input logic [31:0] d2);
        drive(1'b1, ins, pc, d1, d2);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; out_ready = 1'b0;
        drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0);
        #17 rst_n = 1'b1;
        tick();
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++; $display("FAIL reset_handshake: in_ready=%b out_valid=%b, want 1 0", in_ready, out_valid);
        end
        checks++;
        if (dut_out() !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h, want 0", dut_out());
        end
    endtask

    task automatic test_add();
        out_ready = 1'b1;
        drive(1'b1, 32'h002081B3, 32'h40, 32'd5, 32'd7);
        #1;
        checks++;
        if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin
            errors++; $display("FAIL add_rs_addr: got %0d %0d, want 1 2", rs1_addr, rs2_addr);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if ({out_valid, out_opcode, out_a, out_b, out_rd, out_we} !== {1'b1, 7'b0110011, 32'd5, 32'd7, 5'd3, 1'b1}) begin
            errors++;
            $display("FAIL add: valid=%b op=%b a=%h b=%h rd=%0d we=%b, want 1 0110011 5 7 3 1",
                     out_valid, out_opcode, out_a, out_b, out_rd, out_we);
        end
    endtask

    task automatic test_shift();
        out_ready = 1'b1;
        run_one(32'h4040D093, 32'h44, 32'hF000_0000, 32'h1234);
        checks++;
        if ({out_funct7, out_funct3, out_a, out_b, out_we, out_illegal} !==
            {7'b0100000, 3'b101, 32'hF000_0000, 32'd4, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL srai: f7=%b f3=%b a=%h b=%h we=%b ill=%b, want 0100000 101 f0000000 4 1 0",
                     out_funct7, out_funct3, out_a, out_b, out_we, out_illegal);
        end
        run_one(32'h40409093, 32'h48, 32'hDEAD_BEEF, 32'h1);
        checks++;
        if ({out_illegal, out_we, out_rd, out_a, out_b, out_funct7} !== {1'b1, 1'b0, 5'd0, 32'd0, 32'd0, 7'b0100000}) begin
            errors++;
            $display("FAIL slli_bad_f7: ill=%b we=%b rd=%0d a=%h b=%h f7=%b, want 1 0 0 0 0 0100000",
                     out_illegal, out_we, out_rd, out_a, out_b, out_funct7);
        end
    endtask

    task automatic test_jal_lui();
        out_ready = 1'b1;
        run_one(32'h008000EF, 32'h100, 32'h55, 32'h66);
        checks++;
        if ({out_a, out_b, out_tgt, out_jump, out_we, out_rd} !== {32'h100, 32'd4, 32'h108, 1'b1, 1'b1, 5'd1}) begin
            errors++;
            $display("FAIL jal: a=%h b=%h tgt=%h jump=%b we=%b rd=%0d, want 100 4 108 1 1 1",
                     out_a, out_b, out_tgt, out_jump, out_we, out_rd);
        end
        run_one(32'h123452B7, 32'h104, 32'h77, 32'h88);
        checks++;
        if ({out_a, out_b, out_we, out_rd, out_jump} !== {32'h1234_5000, 32'd0, 1'b1, 5'd5, 1'b0}) begin
            errors++;
            $display("FAIL lui: a=%h b=%h we=%b rd=%0d jump=%b, want 12345000 0 1 5 0",
                     out_a, out_b, out_we, out_rd, out_jump);
        end
    endtask

    task automatic test_branch();
        out_ready = 1'b1;
        run_one(32'hFE208EE3, 32'h200, 32'd9, 32'd9);
`ifdef DECODE_BRANCH_EN
        checks++;
        if ({out_br_sel, out_tgt, out_illegal, out_we, out_a, out_b} !==
            {6'b100000, 32'h1FC, 1'b0, 1'b0, 32'd9, 32'd9}) begin
            errors++;
            $display("FAIL beq: br_sel=%b tgt=%h ill=%b we=%b a=%h b=%h, want 100000 1fc 0 0 9 9",
                     out_br_sel, out_tgt, out_illegal, out_we, out_a, out_b);
        end
`else
        checks++;
        if ({out_illegal, out_br_sel, out_tgt, out_we} !== {1'b1, 6'd0, 32'd0, 1'b0}) begin
            errors++;
            $display("FAIL beq_disabled: ill=%b br_sel=%b tgt=%h we=%b, want 1 0 0 0",
                     out_illegal, out_br_sel, out_tgt, out_we);
        end
`endif
        tick();
    endtask

    task automatic test_back_to_back();
        logic [31:0] got[$];
        logic        sent3;
        out_ready = 1'b0;
        drive(1'b1, 32'h00100093, 32'h1000, 32'd0, 32'd0);
        tick();
        drive(1'b1, 32'h00200113, 32'h1004, 32'd0, 32'd0);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready_one: in_ready=%b, want 1", in_ready);
        end
        tick();
        drive(1'b1, 32'h00300193, 32'h1008, 32'd0, 32'd0);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_ready_full: in_ready=%b, want 0", in_ready);
        end
        tick();
        checks++;
        if ({in_ready, out_valid, out_pc} !== {1'b0, 1'b1, 32'h1000}) begin
            errors++; $display("FAIL b2b_hold: in_ready=%b out_valid=%b pc=%h, want 0 1 1000", in_ready, out_valid, out_pc);
        end
        out_ready = 1'b1;
        sent3 = 1'b0;
        for (int n = 0; n < 12; n++) begin
            if (out_valid && out_ready) got.push_back(out_pc);
            if (in_valid && in_ready) sent3 = 1'b1;
            tick();
            if (sent3) in_valid = 1'b0;
        end
        checks++;
        if (got.size() != 3) begin
            errors++; $display("FAIL b2b_count: got %0d entries, want 3", got.size());
        end else begin
            checks++;
            if (got[0] !== 32'h1000 || got[1] !== 32'h1004 || got[2] !== 32'h1008) begin
                errors++; $display("FAIL b2b_order: got %h %h %h, want 1000 1004 1008", got[0], got[1], got[2]);
            end
        end
    endtask

    task automatic test_flush();
        out_ready = 1'b0;
        run_one(32'h00100093, 32'h2000, 32'd0, 32'd0);
        run_one(32'h00200113, 32'h2004, 32'd0, 32'd0);
        drive(1'b1, 32'h00300193, 32'h2008, 32'd0, 32'd0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        in_valid = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL flush_state: out_valid=%b in_ready=%b, want 0 1", out_valid, in_ready);
        end
        out_ready = 1'b1;
        for (int n = 0; n < 3; n++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0) begin
                errors++; $display("FAIL flush_leak: out_valid=%b pc=%h, want 0", out_valid, out_pc);
            end
        end
    endtask

    task automatic test_async_reset();
        out_ready = 1'b0;
        run_one(32'h00100093, 32'h3000, 32'd0, 32'd0);
        run_one(32'h00200113, 32'h3004, 32'd0, 32'd0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({out_valid, in_ready, out_pc} !== {1'b0, 1'b1, 32'd0}) begin
            errors++; $display("FAIL async_reset: out_valid=%b in_ready=%b pc=%h, want 0 1 0", out_valid, in_ready, out_pc);
        end
        #3 rst_n = 1'b1;
        tick();
        checks++;
        if (out_valid !== 1'b0) begin
            errors++; $display("FAIL async_reset_after: out_valid=%b, want 0", out_valid);
        end
    endtask

    task automatic test_random();
        exp_t q[$];
        for (int n = 0; n < 3000; n++) begin
            drive($urandom_range(0, 3) != 0, rand_instr(), $urandom, $urandom, $urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 31) == 0);
            #1;
            checks++;
            if (rs1_addr !== in_instr[19:15] || rs2_addr !== in_instr[24:20]) begin
                errors++; $display("FAIL rnd_rs_addr: got %0d %0d, want %0d %0d",
                                   rs1_addr, rs2_addr, in_instr[19:15], in_instr[24:20]);
            end
            checks++;
            if (out_valid !== (q.size() > 0)) begin
                errors++; $display("FAIL rnd_out_valid: got %b, want %b (cycle %0d)", out_valid, q.size() > 0, n);
            end
            checks++;
            if (in_ready !== (q.size() < 2)) begin
                errors++; $display("FAIL rnd_in_ready: got %b, want %b (cycle %0d)", in_ready, q.size() < 2, n);
            end
            if (flush) begin
                q.delete();
            end else begin
                if (out_valid && out_ready && q.size() > 0) begin
                    checks++;
                    if (dut_out() !== q[0]) begin
                        errors++; $display("FAIL rnd_entry: got %h, want %h (cycle %0d)", dut_out(), q[0], n);
                    end
                    void'(q.pop_front());
                end
                if (in_valid && in_ready) q.push_back(model(in_instr, in_pc, rs1_data, rs2_data));
            end
            tick();
        end
        flush = 1'b0;
        in_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_add();
        test_shift();
        test_jal_lui();
        test_branch();
        test_back_to_back();
        test_flush();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
